// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCode values, SR/Cause field
// positions and the EPC computation used on exception entry.
package cp0_pkg;

  localparam logic [4:0] CP0_REG_SR    = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
  localparam logic [4:0] CP0_REG_EPC   = 5'd14;
  localparam logic [4:0] CP0_REG_PRID  = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  // EXL is the controller state: USER while clear, HANDLER while set.
  typedef enum logic {
    ST_USER    = 1'b0,
    ST_HANDLER = 1'b1
  } exl_state_e;

  localparam int unsigned SR_IE_BIT     = 0;
  localparam int unsigned SR_EXL_BIT    = 1;
  localparam int unsigned SR_IM_LSB     = 10;
  localparam int unsigned SR_IM_MSB     = 15;
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_EXC_MSB = 6;
  localparam int unsigned CAUSE_IP_LSB  = 10;
  localparam int unsigned CAUSE_IP_MSB  = 15;
  localparam int unsigned CAUSE_BD_BIT  = 31;

  // Word-aligned PC of the faulting instruction, backed up to the branch
  // when it sits in a delay slot (wraps modulo 2^32).
  function automatic logic [31:0] epc_of(input logic [31:0] vpc, input logic bd);
    logic [31:0] aligned;
    aligned = vpc & 32'hFFFF_FFFC;
    return bd ? (aligned - 32'd4) : aligned;
  endfunction

endpackage

// File: rtl/cp0_regfile.sv
// CP0 register storage (SR IM/IE, Cause BD/IP/ExcCode, EPC) and the mfc0
// read mux. EXL lives in the controller and is only folded into SR reads.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h2023_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_take,
  input  logic [4:0]  i_exc_code,
  input  logic [31:0] i_vpc,
  input  logic        i_bd,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [5:0]  i_hw_int,
  input  logic        i_exl,
  output logic [31:0] o_rdata,
  output logic [31:0] o_epc,
  output logic [5:0]  o_im,
  output logic        o_ie
);

  logic [5:0]  r_im;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  // Register updates: exception entry has priority over mtc0; IP samples every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im       <= '0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
    end else begin
      r_ip <= i_hw_int;
      if (i_take) begin
        r_exc_code <= i_exc_code;
        r_bd       <= i_bd;
        r_epc      <= epc_of(i_vpc, i_bd);
      end else if (i_we) begin
        case (i_addr)
          CP0_REG_SR: begin
            r_im <= i_wdata[SR_IM_MSB:SR_IM_LSB];
            r_ie <= i_wdata[SR_IE_BIT];
          end
          CP0_REG_EPC: r_epc <= i_wdata & 32'hFFFF_FFFC;
          default: ;
        endcase
      end
    end
  end

  // mfc0 read mux over the registered values; undefined bits read as zero.
  always_comb begin
    o_rdata = '0;
    case (i_addr)
      CP0_REG_SR: begin
        o_rdata[SR_IM_MSB:SR_IM_LSB] = r_im;
        o_rdata[SR_EXL_BIT]          = i_exl;
        o_rdata[SR_IE_BIT]           = r_ie;
      end
      CP0_REG_CAUSE: begin
        o_rdata[CAUSE_BD_BIT]                = r_bd;
        o_rdata[CAUSE_IP_MSB:CAUSE_IP_LSB]   = r_ip;
        o_rdata[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = r_exc_code;
      end
      CP0_REG_EPC:  o_rdata = r_epc;
      CP0_REG_PRID: o_rdata = PRID_VAL;
      default:      o_rdata = '0;
    endcase
  end

  assign o_epc = r_epc;
  assign o_im  = r_im;
  assign o_ie  = r_ie;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// M-stage CP0 exception/interrupt controller: request generation,
// interrupt-over-exception priority and EXL (USER/HANDLER) sequencing.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h2023_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret_m,
  output logic        req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out
);

  exl_state_e  r_state;
  logic        w_exl;
  logic [5:0]  w_im;
  logic        w_ie;
  logic        w_int_req;
  logic        w_exc_req;
  logic        w_we;
  logic [4:0]  w_exc_sel;

  assign w_exl     = (r_state == ST_HANDLER);
  assign w_int_req = w_ie & ~w_exl & (|(hw_int & w_im));
  assign w_exc_req = ~w_exl & (|exc_code_in);
  // Gated by reset so a stale ExcCode cannot request while reset is held.
  assign req       = reset & (w_int_req | w_exc_req);
  assign w_exc_sel = w_int_req ? EXC_INT : exc_code_in;
  assign w_we      = cp0_we & ~req;

  assign handler_pc = HANDLER_PC;

  // EXL sequencing: req enters HANDLER, eret leaves it (beating an mtc0 SR EXL write).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_USER;
    end else if (req) begin
      r_state <= ST_HANDLER;
    end else if (eret_m) begin
      r_state <= ST_USER;
    end else if (w_we && (cp0_addr == CP0_REG_SR)) begin
      r_state <= cp0_wdata[SR_EXL_BIT] ? ST_HANDLER : ST_USER;
    end
  end

  cp0_regfile #(
    .PRID_VAL(PRID_VAL)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .i_take     (req),
    .i_exc_code (w_exc_sel),
    .i_vpc      (vpc),
    .i_bd       (bd_in),
    .i_we       (w_we),
    .i_addr     (cp0_addr),
    .i_wdata    (cp0_wdata),
    .i_hw_int   (hw_int),
    .i_exl      (w_exl),
    .o_rdata    (cp0_rdata),
    .o_epc      (epc_out),
    .o_im       (w_im),
    .o_ie       (w_ie)
  );

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl with hand-computed expected values.
module tb_cp0_exc_ctrl;

  logic        clk;
  logic        reset;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret_m;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  int checks;
  int failures;

  cp0_exc_ctrl #(
    .HANDLER_PC(32'h0000_4180),
    .PRID_VAL  (32'h2023_0007)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cp0_we     (cp0_we),
    .cp0_addr   (cp0_addr),
    .cp0_wdata  (cp0_wdata),
    .cp0_rdata  (cp0_rdata),
    .vpc        (vpc),
    .bd_in      (bd_in),
    .exc_code_in(exc_code_in),
    .hw_int     (hw_int),
    .eret_m     (eret_m),
    .req        (req),
    .handler_pc (handler_pc),
    .epc_out    (epc_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    cp0_addr = addr;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; cp0_we = 1'b0; cp0_addr = 5'd12; cp0_wdata = '0;
    vpc = '0; bd_in = 1'b0; exc_code_in = 5'd5; hw_int = '0; eret_m = 1'b0;

    // 1 reset
    repeat (2) @(posedge clk);
    #1;
    chk("req_in_reset", {31'd0, req}, 32'd0);
    @(negedge clk);
    exc_code_in = 5'd0;
    reset = 1'b1;
    #1;
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_prid", 5'd15, 32'h2023_0007);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_epc", epc_out, 32'h0);
    chk("handler_pc", handler_pc, 32'h0000_4180);

    // read-only Cause
    @(negedge clk);
    cp0_we = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
    tick();
    cp0_we = 1'b0;
    rd("cause_ro", 5'd13, 32'h0);

    // 2 exception
    @(negedge clk);
    exc_code_in = 5'd5; vpc = 32'h3010; bd_in = 1'b0;
    #1;
    chk("exc_req", {31'd0, req}, 32'd1);
    tick();
    chk("exc_req_masked", {31'd0, req}, 32'd0);
    rd("exc_epc", 5'd14, 32'h3010);
    rd("exc_cause", 5'd13, 32'h0000_0014);
    rd("exc_sr", 5'd12, 32'h0000_0002);
    @(negedge clk);
    exc_code_in = 5'd0; eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
    rd("eret1_sr", 5'd12, 32'h0);

    // 3 delay slot
    @(negedge clk);
    exc_code_in = 5'd10; vpc = 32'h3008; bd_in = 1'b1;
    tick();
    exc_code_in = 5'd0; bd_in = 1'b0;
    chk("bd_epc", epc_out, 32'h3004);
    rd("bd_cause", 5'd13, 32'h8000_0028);
    @(negedge clk);
    eret_m = 1'b1;
    tick();
    eret_m = 1'b0;

    // EPC wrap
    @(negedge clk);
    exc_code_in = 5'd4; vpc = 32'h0; bd_in = 1'b1;
    tick();
    exc_code_in = 5'd0; bd_in = 1'b0;
    chk("wrap_epc", epc_out, 32'hFFFF_FFFC);
    rd("wrap_cause", 5'd13, 32'h8000_0010);
    @(negedge clk);
    eret_m = 1'b1;
    tick();
    eret_m = 1'b0;

    // 4 interrupt gating
    @(negedge clk);
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    #1;
    chk("mfc0_old_value", cp0_rdata, 32'h0);
    tick();
    cp0_we = 1'b0;
    rd("sr_write", 5'd12, 32'h0000_0401);
    @(negedge clk);
    hw_int = 6'b000001; vpc = 32'h4000;
    #1;
    chk("int_req", {31'd0, req}, 32'd1);
    tick();
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_epc", 5'd14, 32'h4000);
    rd("int_sr", 5'd12, 32'h0000_0403);
    chk("int_req_in_handler", {31'd0, req}, 32'd0);
    @(negedge clk);
    eret_m = 1'b1; hw_int = 6'b0;
    tick();
    eret_m = 1'b0;
    rd("int_eret_sr", 5'd12, 32'h0000_0401);
    rd("ip_cleared", 5'd13, 32'h0);
    @(negedge clk);
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0400;
    tick();
    cp0_we = 1'b0;
    @(negedge clk);
    hw_int = 6'b000001;
    #1;
    chk("ie0_no_req", {31'd0, req}, 32'd0);
    tick();
    rd("ie0_ip", 5'd13, 32'h0000_0400);
    @(negedge clk);
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0001;
    tick();
    cp0_we = 1'b0;
    chk("im0_no_req", {31'd0, req}, 32'd0);
    rd("im0_sr", 5'd12, 32'h0000_0001);
    @(negedge clk);
    hw_int = 6'b0;
    tick();
    rd("ip_tracks", 5'd13, 32'h0);

    // 5 priority and conflict
    @(negedge clk);
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    tick();
    @(negedge clk);
    hw_int = 6'b000001; exc_code_in = 5'd12; vpc = 32'h6000; bd_in = 1'b0;
    cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h5000;
    #1;
    chk("prio_req", {31'd0, req}, 32'd1);
    tick();
    cp0_we = 1'b0; exc_code_in = 5'd0;
    rd("prio_cause", 5'd13, 32'h0000_0400);
    chk("prio_epc", epc_out, 32'h6000);
    rd("prio_sr", 5'd12, 32'h0000_0403);

    // 6 eret with pending interrupt
    @(negedge clk);
    eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
    rd("eret_sr", 5'd12, 32'h0000_0401);
    chk("eret_epc", epc_out, 32'h6000);
    chk("pending_req", {31'd0, req}, 32'd1);
    tick();
    rd("reentry_sr", 5'd12, 32'h0000_0403);

    // eret together with mtc0 SR: EXL cleared, IM/IE written
    @(negedge clk);
    hw_int = 6'b0; eret_m = 1'b1;
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0C03;
    tick();
    eret_m = 1'b0; cp0_we = 1'b0;
    rd("eret_mtc0_sr", 5'd12, 32'h0000_0C01);

    // mtc0 EPC forces low bits to zero
    @(negedge clk);
    cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_1237;
    tick();
    cp0_we = 1'b0;
    chk("mtc0_epc", epc_out, 32'h0000_1234);

    // reset mid-handler clears asynchronously
    @(negedge clk);
    exc_code_in = 5'd8; vpc = 32'h7000;
    tick();
    rd("sys_sr", 5'd12, 32'h0000_0C03);
    #2;
    reset = 1'b0;
    #1;
    rd("async_sr", 5'd12, 32'h0);
    chk("async_epc", epc_out, 32'h0);
    chk("async_req", {31'd0, req}, 32'd0);
    @(negedge clk);
    reset = 1'b1; exc_code_in = 5'd0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
